// File: rtl/id_ctrl_pkg.sv
// rtl/id_ctrl_pkg.sv - shared types and opcode constants for the decode controller
package id_ctrl_pkg;

  localparam int XLEN_DEFAULT = 64;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    imm_type_e imm_type;
    logic      illegal;
  } decode_t;

endpackage

// File: rtl/id_ctrl_imm_gen.sv
// rtl/id_ctrl_imm_gen.sv - sign-extended immediates for every instruction format
module id_ctrl_imm_gen
  import id_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:7]     inst,
  output logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] imm_s,
  output logic [XLEN-1:0] imm_b,
  output logic [XLEN-1:0] imm_u,
  output logic [XLEN-1:0] imm_j
);

  assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

endmodule

// File: rtl/id_ctrl.sv
// rtl/id_ctrl.sv - decode-stage controller with immediate select and 2-entry skid buffer
module id_ctrl
  import id_ctrl_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [31:0]      if_inst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [31:0]      ex_inst,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_imm,
  output logic [2:0]       ex_imm_type,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  function automatic decode_t classify(input logic [31:0] inst);
    decode_t d;
    d.imm_type = IMM_NONE;
    d.illegal  = 1'b0;
    if (inst[1:0] != 2'b11) begin
      d.illegal = 1'b1;
    end else begin
      case (inst[6:0])
        OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM, OP_FENCE: d.imm_type = IMM_I;
        OP_STORE:                                                d.imm_type = IMM_S;
        OP_BRANCH:                                               d.imm_type = IMM_B;
        OP_LUI, OP_AUIPC:                                        d.imm_type = IMM_U;
        OP_JAL:                                                  d.imm_type = IMM_J;
        OP_OP, OP_OP32:                                          d.imm_type = IMM_NONE;
        default:                                                 d.illegal  = 1'b1;
      endcase
    end
    return d;
  endfunction

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  id_ctrl_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst  (if_inst[31:7]),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_b (imm_b),
    .imm_u (imm_u),
    .imm_j (imm_j)
  );

  decode_t         dec;
  logic [XLEN-1:0] in_imm;

  assign dec = classify(if_inst);

  always_comb begin
    in_imm = '0;
    case (dec.imm_type)
      IMM_I:   in_imm = imm_i;
      IMM_S:   in_imm = imm_s;
      IMM_B:   in_imm = imm_b;
      IMM_U:   in_imm = imm_u;
      IMM_J:   in_imm = imm_j;
      default: in_imm = '0;
    endcase
  end

  state_e          state;
  logic [31:0]     skid_inst;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_imm;
  logic [2:0]      skid_imm_type;
  logic            skid_illegal;

  logic push, pop;
  assign push = if_valid & if_ready;
  assign pop  = ex_valid & ex_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_EMPTY;
      if_ready      <= 1'b1;
      ex_valid      <= 1'b0;
      ex_inst       <= '0;
      ex_pc         <= '0;
      ex_imm        <= '0;
      ex_imm_type   <= '0;
      ex_illegal    <= 1'b0;
      skid_inst     <= '0;
      skid_pc       <= '0;
      skid_imm      <= '0;
      skid_imm_type <= '0;
      skid_illegal  <= 1'b0;
      stall_cnt     <= '0;
    end else begin
      // Performance counter survives flush so debug can see stalls across redirects.
      if (ex_valid && !ex_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);

      if (flush) begin
        state    <= ST_EMPTY;
        ex_valid <= 1'b0;
        if_ready <= 1'b1;
      end else begin
        case (state)
          ST_EMPTY: begin
            if (push) begin
              state       <= ST_ONE;
              ex_valid    <= 1'b1;
              ex_inst     <= if_inst;
              ex_pc       <= if_pc;
              ex_imm      <= in_imm;
              ex_imm_type <= dec.imm_type;
              ex_illegal  <= dec.illegal;
            end
            if_ready <= 1'b1;
          end
          ST_ONE: begin
            if (push && !pop) begin
              state         <= ST_FULL;
              skid_inst     <= if_inst;
              skid_pc       <= if_pc;
              skid_imm      <= in_imm;
              skid_imm_type <= dec.imm_type;
              skid_illegal  <= dec.illegal;
              if_ready      <= 1'b0;
            end else if (push && pop) begin
              ex_inst     <= if_inst;
              ex_pc       <= if_pc;
              ex_imm      <= in_imm;
              ex_imm_type <= dec.imm_type;
              ex_illegal  <= dec.illegal;
              if_ready    <= 1'b1;
            end else if (pop) begin
              state    <= ST_EMPTY;
              ex_valid <= 1'b0;
              if_ready <= 1'b1;
            end else begin
              if_ready <= 1'b1;
            end
          end
          ST_FULL: begin
            // if_ready is low here, so no push can arrive while the skid is occupied.
            if (pop) begin
              state       <= ST_ONE;
              ex_inst     <= skid_inst;
              ex_pc       <= skid_pc;
              ex_imm      <= skid_imm;
              ex_imm_type <= skid_imm_type;
              ex_illegal  <= skid_illegal;
              if_ready    <= 1'b1;
            end else begin
              if_ready <= 1'b0;
            end
          end
          default: begin
            state    <= ST_EMPTY;
            ex_valid <= 1'b0;
            if_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_id_ctrl.sv
// tb/tb_id_ctrl.sv - scoreboard bench for id_ctrl against a queue-based reference model
module tb_id_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic        ex_ready;

  logic        if_ready, ex_valid, ex_illegal;
  logic [31:0] ex_inst;
  logic [63:0] ex_pc, ex_imm;
  logic [2:0]  ex_imm_type;
  logic [31:0] stall_cnt;

  logic        s_if_ready, s_ex_valid, s_ex_illegal;
  logic [31:0] s_ex_inst;
  logic [63:0] s_ex_pc, s_ex_imm;
  logic [2:0]  s_ex_imm_type;
  logic [3:0]  s_stall_cnt;

  always #5 clk = ~clk;

  id_ctrl #(.XLEN(64), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_inst(ex_inst), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_imm_type(ex_imm_type), .ex_illegal(ex_illegal),
    .stall_cnt(stall_cnt)
  );

  id_ctrl #(.XLEN(64), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(s_if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .ex_valid(s_ex_valid), .ex_ready(ex_ready), .ex_inst(s_ex_inst), .ex_pc(s_ex_pc),
    .ex_imm(s_ex_imm), .ex_imm_type(s_ex_imm_type), .ex_illegal(s_ex_illegal),
    .stall_cnt(s_stall_cnt)
  );

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  longint unsigned stall_m = 0;
  int   stall4_m = 0;
  bit   chk_zero = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sext(input longint unsigned v, input int w);
    longint s;
    s = longint'(v << (64 - w));
    return 64'(s >>> (64 - w));
  endfunction

  function automatic exp_t model(input logic [31:0] inst, input logic [63:0] pc);
    exp_t e;
    longint unsigned u;
    u = 64'(inst);
    e.inst = inst;
    e.pc   = pc;
    e.imm  = 64'd0;
    e.typ  = 3'd0;
    e.ill  = 1'b0;
    if ((u & 3) != 3) begin
      e.ill = 1'b1;
    end else begin
      case (u & 'h7f)
        'h03, 'h13, 'h1b, 'h67, 'h73, 'h0f: begin
          e.typ = 3'd1; e.imm = sext(u >> 20, 12);
        end
        'h23: begin
          e.typ = 3'd2; e.imm = sext(((u >> 25) << 5) | ((u >> 7) & 'h1f), 12);
        end
        'h63: begin
          e.typ = 3'd3;
          e.imm = sext((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                       (((u >> 25) & 'h3f) << 5) | (((u >> 8) & 'hf) << 1), 13);
        end
        'h37, 'h17: begin
          e.typ = 3'd4; e.imm = sext(u & 'hfffff000, 32);
        end
        'h6f: begin
          e.typ = 3'd5;
          e.imm = sext((((u >> 31) & 1) << 20) | (((u >> 12) & 'hff) << 12) |
                       (((u >> 20) & 1) << 11) | (((u >> 21) & 'h3ff) << 1), 21);
        end
        'h33, 'h3b: e.typ = 3'd0;
        default:    e.ill = 1'b1;
      endcase
    end
    return e;
  endfunction

  // Monitor: checks DUT state against the model queue, then advances the model.
  always @(negedge clk) begin
    int sz;
    if (rst) begin
      q.delete();
      stall_m  = 0;
      stall4_m = 0;
      chk_zero = 1'b1;
    end else begin
      sz = q.size();
      if (chk_zero) begin
        chk("rst_ex_inst", 64'(ex_inst), 64'd0);
        chk("rst_ex_pc", ex_pc, 64'd0);
        chk("rst_ex_imm", ex_imm, 64'd0);
        chk("rst_ex_type", 64'(ex_imm_type), 64'd0);
        chk("rst_ex_illegal", 64'(ex_illegal), 64'd0);
        chk_zero = 1'b0;
      end
      chk("ex_valid", 64'(ex_valid), 64'(sz != 0));
      chk("if_ready", 64'(if_ready), 64'(sz < 2));
      chk("stall_cnt", 64'(stall_cnt), stall_m);
      chk("stall_cnt_sat", 64'(s_stall_cnt), 64'(stall4_m));
      if (sz != 0) begin
        chk("ex_inst", 64'(ex_inst), 64'(q[0].inst));
        chk("ex_pc", ex_pc, q[0].pc);
        chk("ex_imm", ex_imm, q[0].imm);
        chk("ex_imm_type", 64'(ex_imm_type), 64'(q[0].typ));
        chk("ex_illegal", 64'(ex_illegal), 64'(q[0].ill));
        if (!ex_ready) begin
          stall_m++;
          if (stall4_m < 15) stall4_m++;
        end else begin
          void'(q.pop_front());
        end
      end
      if (flush) q.delete();
      else if (if_valid && sz < 2) q.push_back(model(if_inst, if_pc));
    end
  end

  task automatic step(input bit v, input logic [31:0] inst, input logic [63:0] pc,
                      input bit r, input bit f);
    if_valid = v;
    if_inst  = inst;
    if_pc    = pc;
    ex_ready = r;
    flush    = f;
    @(posedge clk);
    #1;
  endtask

  logic [6:0] ops [16] = '{7'h03, 7'h13, 7'h1b, 7'h67, 7'h73, 7'h0f, 7'h23, 7'h63,
                           7'h37, 7'h17, 7'h6f, 7'h33, 7'h3b, 7'h7f, 7'h00, 7'h2b};

  initial begin
    logic [31:0] r, inst;
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_inst = '0; if_pc = '0; ex_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, 0, 0, 1, 0);

    step(1, 32'hFFF00093, 64'h80000000, 1, 0);
    step(1, 32'h00112623, 64'h80000004, 1, 0);
    step(1, 32'hFE000EE3, 64'h80000008, 1, 0);
    step(1, 32'h800002B7, 64'h8000000C, 1, 0);
    step(1, 32'h0000006F, 64'h80000010, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    for (int i = 0; i < 20; i++) step(1, 32'h00100093 + 32'(i << 20), 64'h1000 + 64'(4 * i), 0, 0);
    repeat (4) step(0, 0, 0, 1, 0);

    step(1, 32'h00000000, 64'h2000, 1, 0);
    step(1, 32'h0000007F, 64'h2004, 1, 0);
    step(1, 32'h00B50533, 64'h2008, 1, 0);
    step(0, 0, 0, 1, 0);

    step(1, 32'h00112623, 64'h3000, 0, 0);
    step(1, 32'h800002B7, 64'h3004, 0, 0);
    step(1, 32'hFFF00093, 64'h3008, 0, 1);
    repeat (3) step(0, 0, 0, 1, 0);

    step(1, 32'h00112623, 64'h4000, 0, 0);
    step(1, 32'h0000006F, 64'h4004, 0, 0);
    step(0, 0, 0, 0, 0);
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    rst = 1'b0;
    repeat (2) step(0, 0, 0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      inst = {r[31:7], ops[$urandom_range(0, 15)]};
      if ($urandom_range(0, 9) == 0) inst = $urandom();
      step($urandom_range(0, 3) != 0, inst, {32'h0, $urandom()}, $urandom_range(0, 2) != 0,
           $urandom_range(0, 29) == 0);
    end
    repeat (4) step(0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
